// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer for a single full-scan chain: per pattern it loads the chain, captures once,
// unloads the response and presents it with a pass/fail compare against expected values.
module scan_test_ctrl #(
  parameter int unsigned CHAIN_LEN = 3,
  parameter int unsigned NUM_PI    = 4,
  parameter int unsigned NUM_PO    = 1
) (
  input  logic                 CK,
  input  logic                 RSTN,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_scan,
  input  logic [NUM_PI-1:0]    pat_pi,
  input  logic [CHAIN_LEN-1:0] exp_scan,
  input  logic [NUM_PO-1:0]    exp_po,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic [NUM_PI-1:0]    pi,
  input  logic                 scan_out,
  input  logic [NUM_PO-1:0]    po,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_scan,
  output logic [NUM_PO-1:0]    rsp_po,
  output logic                 rsp_fail
);

  localparam int unsigned CntW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCapture, StUnload, StResp} state_e;

  state_e r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;

  logic [CHAIN_LEN-1:0] r_pat_scan, r_exp_scan;
  logic [NUM_PI-1:0]    r_pat_pi;
  logic [NUM_PO-1:0]    r_exp_po;

  logic                 r_pat_ready, w_pat_ready_d;
  logic                 r_scan_en, w_scan_en_d;
  logic                 r_scan_in, w_scan_in_d;
  logic [NUM_PI-1:0]    r_pi, w_pi_d;
  logic                 r_rsp_valid, w_rsp_valid_d;
  logic [CHAIN_LEN-1:0] r_rsp_scan, w_rsp_scan_d;
  logic [NUM_PO-1:0]    r_rsp_po, w_rsp_po_d;
  logic                 r_rsp_fail, w_rsp_fail_d;

  logic                 w_accept;
  logic [CHAIN_LEN-1:0] w_scan_src;
  logic [NUM_PI-1:0]    w_pi_src;

  assign w_accept = (r_state == StIdle) && pat_valid && r_pat_ready;

  // Outputs are registered from next state, so the accepting edge must see the live pattern.
  assign w_scan_src = w_accept ? pat_scan : r_pat_scan;
  assign w_pi_src   = w_accept ? pat_pi : r_pat_pi;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StLoad;
          w_cnt_d   = '0;
        end
      end
      StLoad: begin
        if (r_cnt == LastCnt) begin
          w_state_d = StCapture;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StCapture: begin
        w_state_d = StUnload;
        w_cnt_d   = '0;
      end
      StUnload: begin
        if (r_cnt == LastCnt) begin
          w_state_d = StResp;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StResp: begin
        if (r_rsp_valid && rsp_ready) w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    w_pat_ready_d = (w_state_d == StIdle);
    w_scan_en_d   = (w_state_d == StLoad) || (w_state_d == StUnload);
    w_scan_in_d   = (w_state_d == StLoad) ? w_scan_src[w_cnt_d] : 1'b0;
    w_pi_d        = ((w_state_d == StLoad) || (w_state_d == StCapture)) ? w_pi_src : '0;
    w_rsp_valid_d = (w_state_d == StResp);

    w_rsp_po_d = r_rsp_po;
    if (r_state == StCapture) w_rsp_po_d = po;

    // scan_out still shows the pre-shift cell on the edge ending each unload cycle.
    w_rsp_scan_d = r_rsp_scan;
    if (r_state == StUnload) w_rsp_scan_d[r_cnt] = scan_out;

    w_rsp_fail_d = r_rsp_fail;
    if ((r_state == StUnload) && (r_cnt == LastCnt)) begin
      w_rsp_fail_d = (w_rsp_scan_d != r_exp_scan) || (w_rsp_po_d != r_exp_po);
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_pat_scan  <= '0;
      r_exp_scan  <= '0;
      r_pat_pi    <= '0;
      r_exp_po    <= '0;
      r_pat_ready <= 1'b0;
      r_scan_en   <= 1'b0;
      r_scan_in   <= 1'b0;
      r_pi        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_scan  <= '0;
      r_rsp_po    <= '0;
      r_rsp_fail  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pat_scan <= pat_scan;
        r_exp_scan <= exp_scan;
        r_pat_pi   <= pat_pi;
        r_exp_po   <= exp_po;
      end
      r_pat_ready <= w_pat_ready_d;
      r_scan_en   <= w_scan_en_d;
      r_scan_in   <= w_scan_in_d;
      r_pi        <= w_pi_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_scan  <= w_rsp_scan_d;
      r_rsp_po    <= w_rsp_po_d;
      r_rsp_fail  <= w_rsp_fail_d;
    end
  end

  assign pat_ready = r_pat_ready;
  assign scan_en   = r_scan_en;
  assign scan_in   = r_scan_in;
  assign pi        = r_pi;
  assign rsp_valid = r_rsp_valid;
  assign rsp_scan  = r_rsp_scan;
  assign rsp_po    = r_rsp_po;
  assign rsp_fail  = r_rsp_fail;

endmodule
